// File: rtl/ebpf_insn_sequencer_pkg.sv
// Shared types for the eBPF fetch/retire sequencer: FSM states, control-unit
// exception codes and the branch request captured at EXEC.
package ebpf_insn_sequencer_pkg;

    localparam int PC_W_DEF = 16;
    localparam int BR_OFF_W = 16;

    typedef enum logic [1:0] {
        NO_EXCEPTION    = 2'd0,
        EXIT            = 2'd1,
        UNKNOWN_OPCODE  = 2'd2,
        INCOMPLETE_LDDW = 2'd3
    } exc_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_EXEC,
        S_MEM_WAIT,
        S_DRAIN,
        S_END
    } seq_state_e;

    typedef struct packed {
        logic                taken;
        logic [BR_OFF_W-1:0] off;
    } branch_t;

endpackage

// File: rtl/ebpf_insn_sequencer_if.sv
// Instruction-memory and decode/control handshake bundle of the sequencer.
// master = sequencer side, slave = memory/control side.
interface ebpf_insn_sequencer_if
    import ebpf_insn_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
);
    logic                imem_req;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_gnt;
    logic                imem_rvalid;
    logic [63:0]         imem_rdata;
    logic [63:0]         insn;
    logic                insn_valid;
    logic [1:0]          ctrl_exc;
    logic                exc_caught;
    logic                branch_taken;
    logic [BR_OFF_W-1:0] branch_off;
    logic                mem_op;
    logic                mem_done;
    logic                commit;

    modport master (
        output imem_req, imem_addr, insn, insn_valid, exc_caught, commit,
        input  imem_gnt, imem_rvalid, imem_rdata, ctrl_exc, branch_taken,
               branch_off, mem_op, mem_done
    );

    modport slave (
        input  imem_req, imem_addr, insn, insn_valid, exc_caught, commit,
        output imem_gnt, imem_rvalid, imem_rdata, ctrl_exc, branch_taken,
               branch_off, mem_op, mem_done
    );

endinterface

// File: rtl/ebpf_pc_next.sv
// Next-PC adder: pc+1, or pc+1+sext(off) for a taken branch, modulo 2^PC_W.
module ebpf_pc_next
    import ebpf_insn_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] i_pc,
    input  branch_t         i_br,
    output logic [PC_W-1:0] o_pc_next
);
    logic [PC_W-1:0] w_off;

    // Sizing cast of a signed value sign-extends (or truncates) to PC_W.
    assign w_off     = i_br.taken ? PC_W'($signed(i_br.off)) : '0;
    assign o_pc_next = i_pc + PC_W'(1) + w_off;

endmodule

// File: rtl/ebpf_insn_sequencer.sv
// Fetch/retire sequencer: owns the PC, fetches one instruction at a time,
// stalls on data-memory ops, applies branches and terminates the run.
module ebpf_insn_sequencer
    import ebpf_insn_sequencer_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int MAX_STEPS = 65535,
    parameter int STEP_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic [PC_W-1:0]       i_start_pc,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_exc_code,
    output logic [PC_W-1:0]       o_exc_pc,
    output logic                  o_timeout,
    output logic [STEP_W-1:0]     o_steps,
    ebpf_insn_sequencer_if.master bus
);
    seq_state_e        r_state;
    logic [PC_W-1:0]   r_pc;
    logic [STEP_W-1:0] r_steps;
    logic [63:0]       r_insn;
    exc_code_e         r_exc_code;
    logic [PC_W-1:0]   r_exc_pc;
    logic              r_timeout;
    branch_t           r_br;

    logic              w_exc_hit;
    logic              w_retire;
    logic              w_budget_hit;
    branch_t           w_br_live;
    branch_t           w_br_sel;
    logic [PC_W-1:0]   w_pc_next;
    logic [STEP_W-1:0] w_steps_inc;

    assign w_exc_hit    = (bus.ctrl_exc != NO_EXCEPTION);
    assign w_br_live    = '{taken: bus.branch_taken, off: bus.branch_off};
    // Branch inputs are only valid in EXEC; a stalled load retires with the captured copy.
    assign w_br_sel     = (r_state == S_MEM_WAIT) ? r_br : w_br_live;
    assign w_steps_inc  = r_steps + STEP_W'(1);
    assign w_budget_hit = (MAX_STEPS != 0) && (w_steps_inc == STEP_W'(MAX_STEPS));

    assign w_retire = !i_abort &&
        (((r_state == S_EXEC) && !w_exc_hit && (!bus.mem_op || bus.mem_done)) ||
         ((r_state == S_MEM_WAIT) && bus.mem_done));

    ebpf_pc_next #(.PC_W(PC_W)) u_pc_next (
        .i_pc      (r_pc),
        .i_br      (w_br_sel),
        .o_pc_next (w_pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_steps    <= '0;
            r_insn     <= '0;
            r_exc_code <= NO_EXCEPTION;
            r_exc_pc   <= '0;
            r_timeout  <= 1'b0;
            r_br       <= '0;
        end else if (i_abort && (r_state != S_IDLE)) begin
            // A granted fetch must have its read data drained before going idle.
            case (r_state)
                S_FETCH:            r_state <= bus.imem_gnt ? S_DRAIN : S_IDLE;
                S_WAIT_RD, S_DRAIN: r_state <= bus.imem_rvalid ? S_IDLE : S_DRAIN;
                default:            r_state <= S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc       <= i_start_pc;
                        r_steps    <= '0;
                        r_exc_code <= NO_EXCEPTION;
                        r_exc_pc   <= '0;
                        r_timeout  <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH:   if (bus.imem_gnt) r_state <= S_WAIT_RD;
                S_WAIT_RD: begin
                    if (bus.imem_rvalid) begin
                        r_insn  <= bus.imem_rdata;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_exc_hit) begin
                        r_exc_code <= exc_code_e'(bus.ctrl_exc);
                        r_exc_pc   <= r_pc;
                        r_state    <= S_END;
                    end else if (bus.mem_op && !bus.mem_done) begin
                        r_br    <= w_br_live;
                        r_state <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: r_state <= S_MEM_WAIT;
                S_DRAIN:    if (bus.imem_rvalid) r_state <= S_IDLE;
                S_END:      r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase

            if (w_retire) begin
                r_steps <= w_steps_inc;
                r_pc    <= w_pc_next;
                if (w_budget_hit) begin
                    r_timeout  <= 1'b1;
                    r_exc_code <= NO_EXCEPTION;
                    r_exc_pc   <= w_pc_next;
                    r_state    <= S_END;
                end else begin
                    r_state <= S_FETCH;
                end
            end
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_END);
    assign o_exc_code = r_exc_code;
    assign o_exc_pc   = r_exc_pc;
    assign o_timeout  = r_timeout;
    assign o_steps    = r_steps;

    assign bus.imem_req   = (r_state == S_FETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.insn       = r_insn;
    assign bus.insn_valid = (r_state == S_EXEC);
    assign bus.commit     = w_retire;
    assign bus.exc_caught = !i_abort && (r_state == S_EXEC) && w_exc_hit;

endmodule

// File: tb/tb_ebpf_insn_sequencer.sv
// Bench for ebpf_insn_sequencer: directed and random programs checked against
// an ISA-level walk of the program (fetch list, retired PCs, final status).
module tb_ebpf_insn_sequencer;

    localparam int MAXS = 4;
    localparam logic [7:0] K_ALU = 8'd0, K_BR = 8'd1, K_LD = 8'd2,
                           K_EXIT = 8'd3, K_BAD2 = 8'd4, K_BAD3 = 8'd5;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [15:0] start_pc;
    logic        busy, done, timeout;
    logic [1:0]  exc_code;
    logic [15:0] exc_pc;
    logic [31:0] steps;

    ebpf_insn_sequencer_if #(.PC_W(16)) bus ();

    ebpf_insn_sequencer #(.PC_W(16), .MAX_STEPS(MAXS), .STEP_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_start_pc(start_pc),
        .i_abort(abort), .o_busy(busy), .o_done(done), .o_exc_code(exc_code),
        .o_exc_pc(exc_pc), .o_timeout(timeout), .o_steps(steps), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [63:0] prog [logic [15:0]];
    int          gnt_delay = 0;
    int          rd_lat    = 1;
    logic [15:0] flog [$];
    int          n_assert = 0;
    int          n_fail   = 0;

    logic [15:0] exp_commits [$];
    logic [15:0] exp_fetch [$];
    logic [1:0]  exp_code;
    logic [15:0] exp_pc;
    logic        exp_to;
    int          exp_steps;
    int          g_first_iv;
    int          g_commit_cycs [$];

    // word: [63:48] pc tag, [47:40] payload, [35:32] mem latency, [24] taken, [23:8] off, [7:0] kind
    function automatic logic [63:0] mk(input logic [7:0] k, input logic [15:0] pc,
                                       input logic [15:0] off, input logic tk,
                                       input logic [3:0] lat, input logic [7:0] pay);
        return {pc, pay, 4'h0, lat, 7'h0, tk, off, k};
    endfunction

    function automatic logic [63:0] rd(input logic [15:0] a);
        if (prog.exists(a)) return prog[a];
        return mk(K_ALU, a, 16'h0, 1'b0, 4'h0, 8'h0);
    endfunction

    // Instruction memory: grant after gnt_delay cycles of request, data rd_lat cycles later.
    bit          pend;
    int          rcnt, gwait;
    logic [15:0] raddr;
    always @(negedge clk) begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        if (!rst_n) begin
            pend = 0; gwait = gnt_delay; bus.imem_rdata = '0;
        end else if (pend) begin
            if (rcnt <= 1) begin
                bus.imem_rvalid = 1'b1; bus.imem_rdata = rd(raddr); pend = 0;
            end else rcnt--;
        end else if (bus.imem_req) begin
            if (gwait == 0) begin
                bus.imem_gnt = 1'b1; raddr = bus.imem_addr; flog.push_back(raddr);
                pend = 1; rcnt = rd_lat; gwait = gnt_delay;
            end else gwait--;
        end else gwait = gnt_delay;
    end

    // Control unit and data memory: outside EXEC the inputs carry garbage on purpose.
    logic [3:0] mcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mcnt <= 4'd0;
        else if (bus.insn_valid && bus.mem_op && !bus.mem_done && !abort) mcnt <= bus.insn[35:32];
        else if (mcnt != 4'd0) mcnt <= mcnt - 4'd1;
    end

    always_comb begin
        bus.ctrl_exc     = 2'b11;
        bus.branch_taken = 1'b1;
        bus.branch_off   = 16'h7777;
        bus.mem_op       = 1'b1;
        if (bus.insn_valid) begin
            case (bus.insn[7:0])
                K_EXIT:  bus.ctrl_exc = 2'd1;
                K_BAD2:  bus.ctrl_exc = 2'd2;
                K_BAD3:  bus.ctrl_exc = 2'd3;
                default: bus.ctrl_exc = 2'd0;
            endcase
            bus.branch_taken = (bus.insn[7:0] == K_BR) && bus.insn[24];
            bus.branch_off   = bus.insn[23:8];
            bus.mem_op       = (bus.insn[7:0] == K_LD);
        end
        bus.mem_done = (bus.insn_valid && bus.insn[7:0] == K_LD && bus.insn[35:32] == 4'd0) ||
                       (mcnt == 4'd1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural walk of the program: what gets fetched, retired, and how the run ends.
    task automatic model(input logic [15:0] spc);
        logic [15:0] pc;
        logic [63:0] w;
        exp_commits.delete(); exp_fetch.delete();
        pc = spc; exp_steps = 0; exp_to = 0; exp_code = 2'd0; exp_pc = 16'h0;
        for (int i = 0; i < 64; i++) begin
            w = rd(pc);
            exp_fetch.push_back(pc);
            if (w[7:0] == K_EXIT || w[7:0] == K_BAD2 || w[7:0] == K_BAD3) begin
                exp_code = (w[7:0] == K_EXIT) ? 2'd1 : (w[7:0] == K_BAD2) ? 2'd2 : 2'd3;
                exp_pc = pc;
                break;
            end
            exp_commits.push_back(pc);
            exp_steps++;
            pc = (w[7:0] == K_BR && w[24]) ? pc + 16'd1 + w[23:8] : pc + 16'd1;
            if (exp_steps == MAXS) begin
                exp_to = 1'b1; exp_pc = pc;
                break;
            end
        end
    endtask

    task automatic run_prog(input string tag, input logic [15:0] spc);
        int k, fb, iv, ec, ld_exec, ld_lat;
        bit ld_out, seen_done;
        logic [15:0] got [$];
        model(spc);
        g_commit_cycs.delete();
        iv = 0; ec = 0; ld_out = 0; seen_done = 0; g_first_iv = -1; ld_exec = 0; ld_lat = 0;
        @(negedge clk);
        fb = flog.size(); start = 1'b1; start_pc = spc;
        @(negedge clk);
        start = 1'b0; k = 1;
        while (!seen_done && k < 400) begin
            if (bus.insn_valid) begin
                iv++;
                if (g_first_iv < 0) g_first_iv = k;
                chk({tag, " insn"}, bus.insn, rd(flog[flog.size()-1]));
                if (bus.mem_op && !bus.mem_done) begin
                    ld_out = 1; ld_exec = k; ld_lat = int'(bus.insn[35:32]);
                end
            end
            if (bus.imem_req) chk({tag, " fetch_while_mem"}, 64'(ld_out), 64'd0);
            if (bus.commit) begin
                got.push_back(bus.insn[63:48]);
                g_commit_cycs.push_back(k);
                if (ld_out) chk({tag, " ld_commit_cyc"}, 64'(k - ld_exec), 64'(ld_lat));
                ld_out = 0;
            end
            if (bus.exc_caught) ec++;
            if (done) seen_done = 1;
            @(negedge clk);
            k++;
        end
        chk({tag, " done_seen"}, 64'(seen_done), 64'd1);
        chk({tag, " done_pulse"}, 64'(done), 64'd0);
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
        chk({tag, " exc_code"}, 64'(exc_code), 64'(exp_code));
        chk({tag, " exc_pc"}, 64'(exc_pc), 64'(exp_pc));
        chk({tag, " timeout"}, 64'(timeout), 64'(exp_to));
        chk({tag, " steps"}, 64'(steps), 64'(exp_steps));
        chk({tag, " exc_caught"}, 64'(ec), 64'(exp_code != 2'd0));
        chk({tag, " n_commit"}, 64'(got.size()), 64'(exp_commits.size()));
        for (int i = 0; i < got.size() && i < exp_commits.size(); i++)
            chk($sformatf("%s commit_pc%0d", tag, i), 64'(got[i]), 64'(exp_commits[i]));
        chk({tag, " n_fetch"}, 64'(flog.size() - fb), 64'(exp_fetch.size()));
        for (int i = 0; i < exp_fetch.size() && fb + i < flog.size(); i++)
            chk($sformatf("%s fetch_pc%0d", tag, i), 64'(flog[fb+i]), 64'(exp_fetch[i]));
        chk({tag, " n_insn_valid"}, 64'(iv), 64'(exp_fetch.size()));
    endtask

    initial begin
        int fb, nb, niv, ndone, ncom;
        logic [15:0] spc;
        int r;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_pc = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst exc_code", 64'(exc_code), 64'd0);
        chk("rst exc_pc", 64'(exc_pc), 64'd0);
        chk("rst timeout", 64'(timeout), 64'd0);
        chk("rst steps", 64'(steps), 64'd0);
        chk("rst insn", bus.insn, 64'd0);
        chk("rst imem_req", 64'(bus.imem_req), 64'd0);
        chk("rst insn_valid", 64'(bus.insn_valid), 64'd0);
        chk("rst commit", 64'(bus.commit), 64'd0);
        rst_n = 1'b1;

        // 1: three ALU ops then EXIT, 1-cycle memory
        prog.delete(); gnt_delay = 0; rd_lat = 1;
        prog[16'h13] = mk(K_EXIT, 16'h13, 16'h0, 1'b0, 4'h0, 8'h5A);
        run_prog("t1", 16'h10);
        chk("t1 exc_pc_const", 64'(exc_pc), 64'h13);
        chk("t1 steps_const", 64'(steps), 64'd3);
        chk("t1 first_insn_latency", 64'(g_first_iv), 64'd3);
        for (int i = 1; i < g_commit_cycs.size(); i++)
            chk("t1 retire_interval", 64'(g_commit_cycs[i] - g_commit_cycs[i-1]), 64'd3);

        // 2: backward taken branch, and not-taken branch wrapping past 0xFFFF
        prog.delete();
        prog[16'h5] = mk(K_BR, 16'h5, 16'hFFFD, 1'b1, 4'h0, 8'h00);
        prog[16'h3] = mk(K_EXIT, 16'h3, 16'h0, 1'b0, 4'h0, 8'h11);
        run_prog("t2a", 16'h5);
        prog.delete();
        prog[16'hFFFF] = mk(K_BR, 16'hFFFF, 16'h0001, 1'b0, 4'h0, 8'h00);
        prog[16'h0]    = mk(K_EXIT, 16'h0, 16'h0, 1'b0, 4'h0, 8'h22);
        run_prog("t2b", 16'hFFFF);
        chk("t2b exc_pc_wrap", 64'(exc_pc), 64'h0);

        // 3: load completing 4 cycles after EXEC
        prog.delete(); rd_lat = 2;
        prog[16'h40] = mk(K_LD, 16'h40, 16'h0, 1'b0, 4'd4, 8'h33);
        prog[16'h41] = mk(K_EXIT, 16'h41, 16'h0, 1'b0, 4'h0, 8'h44);
        run_prog("t3", 16'h40);

        // 4: unknown opcode
        prog.delete(); rd_lat = 1;
        prog[16'h7] = mk(K_BAD2, 16'h7, 16'h0, 1'b0, 4'h0, 8'h55);
        run_prog("t4", 16'h7);

        // 5: endless self-loop hits the step budget
        prog.delete(); gnt_delay = 1;
        prog[16'h30] = mk(K_BR, 16'h30, 16'hFFFF, 1'b1, 4'h0, 8'h66);
        run_prog("t5", 16'h30);
        chk("t5 timeout_const", 64'(timeout), 64'd1);

        // 6: abort in WAIT_RD, read data arrives 5 cycles after grant
        prog.delete(); gnt_delay = 0; rd_lat = 5;
        @(negedge clk); start = 1'b1; start_pc = 16'h20;
        @(negedge clk); start = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        nb = 0; niv = 0; ndone = 0; ncom = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            nb++;
            niv += int'(bus.insn_valid); ndone += int'(done); ncom += int'(bus.commit);
            @(negedge clk);
        end
        chk("t6 drain_cycles", 64'(nb), 64'd4);
        chk("t6 insn_valid", 64'(niv), 64'd0);
        chk("t6 done", 64'(ndone), 64'd0);
        chk("t6 commit", 64'(ncom), 64'd0);
        rd_lat = 1;
        prog[16'h20] = mk(K_EXIT, 16'h20, 16'h0, 1'b0, 4'h0, 8'h77);
        run_prog("t6 restart", 16'h20);

        // abort in FETCH before grant goes straight to idle
        gnt_delay = 3;
        @(negedge clk); fb = flog.size(); start = 1'b1; start_pc = 16'h50;
        @(negedge clk); start = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("fetch_abort busy", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        chk("fetch_abort no_grant", 64'(flog.size() - fb), 64'd0);
        chk("fetch_abort done", 64'(done), 64'd0);

        // async reset in the middle of a run
        gnt_delay = 0; rd_lat = 3; prog.delete();
        @(negedge clk); start = 1'b1; start_pc = 16'h60;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst busy", 64'(busy), 64'd0);
        chk("async_rst steps", 64'(steps), 64'd0);
        chk("async_rst insn", bus.insn, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // random programs
        for (r = 0; r < 12; r++) begin
            prog.delete();
            spc = 16'($urandom);
            gnt_delay = $urandom_range(0, 2);
            rd_lat = $urandom_range(1, 3);
            for (int i = 0; i < 8; i++) begin
                int sel;
                logic [7:0] kd;
                sel = $urandom_range(0, 9);
                kd = (sel < 4) ? K_ALU : (sel < 6) ? K_BR : (sel < 8) ? K_LD :
                     (sel == 8) ? K_EXIT : (($urandom_range(0, 1) == 0) ? K_BAD2 : K_BAD3);
                prog[spc + 16'(i)] = mk(kd, spc + 16'(i), 16'($urandom_range(0, 8)) - 16'd4,
                                        1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
                                        8'($urandom));
            end
            run_prog($sformatf("rand%0d", r), spc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
